adat_rx_tdm_out: RTL and testbench

Downstream serializer for the ADAT receiver. Takes each decoded 8-channel frame (`o_channels`/`o_valid`/`o_locked` of `adat_rx_adat_rx`) and emits it as one 256-bit TDM8 frame (8 slots × 32 bits) toward a codec or DSP. The bit clock is an integer division of `i_clk`. One frame is buffered, so an ADAT frame that arrives during transmission goes out immediately afterwards.

---
 rtl/adat_rx_tdm_out.sv | 120 ++++++++++++
 tb/tb_adat_rx_tdm_out.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adat_rx_tdm_out.sv
// Serialises each locked 8x24 ADAT frame into a 256-bit TDM8 frame (8 slots x 32 bits, MSB first, left-justified).
// Latency: i_valid at edge E0 sets hold_full; the frame starts at E1 (fsync/sdata valid after E1). A frame lasts 256*BCLK_DIV cycles.
// No backpressure: one frame is held; a write over a held, unloaded frame overwrites it and sets the sticky o_overrun.
module adat_rx_tdm_out #(
    parameter int BCLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_channels [0:7],
    input  logic        i_valid,
    input  logic        i_locked,
    output logic        o_bclk,
    output logic        o_fsync,
    output logic        o_sdata,
    output logic        o_busy,
    output logic        o_overrun
);
    localparam int CW = $clog2(BCLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BCLK_DIV / 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [23:0]    hold [0:7];
    logic [23:0]    sh   [0:7];
    logic           hold_full;
    logic           lock_q;
    logic [CW-1:0]  cnt;
    logic [7:0]     k;

    logic           wr;
    logic           load;
    logic           frame_end;
    logic [CW-1:0]  cnt_nxt;
    logic [7:0]     k_nxt;
    logic           nxt_bit;

    // Decode write/load events and the serial bit for the next bit index.
    always_comb begin
        wr        = i_valid && i_locked;
        frame_end = (state == RUN) && (cnt == CNT_LAST) && (k == 8'hFF);
        load      = hold_full && ((state == IDLE) || frame_end);
        cnt_nxt   = cnt + CW'(1);
        k_nxt     = k + 8'd1;
        nxt_bit   = 1'b0;
        // Slot bits 31..8 carry the sample MSB first, bits 7..0 are zero padding.
        if (k_nxt[4:0] < 5'd24) begin
            nxt_bit = sh[k_nxt[7:5]][5'd23 - k_nxt[4:0]];
        end
    end

    // Hold buffer, its full flag and the sticky overrun flag; the shifter reads the old contents on a simultaneous load.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hold      <= '{default: '0};
            hold_full <= 1'b0;
            lock_q    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            lock_q <= i_locked;
            if (wr) begin
                hold      <= i_channels;
                hold_full <= 1'b1;
            end else if (load || (lock_q && !i_locked)) begin
                hold_full <= 1'b0;
            end
            if (!lock_q && i_locked) begin
                o_overrun <= 1'b0;
            end
            if (wr && hold_full && !load) begin
                o_overrun <= 1'b1;
            end
        end
    end

    // IDLE/RUN sequencer: bit divider, bit index and registered TDM outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            sh      <= '{default: '0};
            cnt     <= '0;
            k       <= 8'd0;
            o_bclk  <= 1'b0;
            o_fsync <= 1'b0;
            o_sdata <= 1'b0;
            o_busy  <= 1'b0;
        end else if (load) begin
            // Start (or seamlessly restart) a frame at bit 0 of slot 0.
            state   <= RUN;
            sh      <= hold;
            cnt     <= '0;
            k       <= 8'd0;
            o_bclk  <= 1'b0;
            o_fsync <= 1'b1;
            o_sdata <= hold[0][23];
            o_busy  <= 1'b1;
        end else if (state == RUN) begin
            if (cnt != CNT_LAST) begin
                cnt    <= cnt_nxt;
                o_bclk <= (cnt_nxt >= CNT_HALF);
            end else if (k != 8'hFF) begin
                cnt     <= '0;
                k       <= k_nxt;
                o_bclk  <= 1'b0;
                o_fsync <= 1'b0;
                o_sdata <= nxt_bit;
            end else begin
                state   <= IDLE;
                cnt     <= '0;
                k       <= 8'd0;
                o_bclk  <= 1'b0;
                o_fsync <= 1'b0;
                o_sdata <= 1'b0;
                o_busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adat_rx_tdm_out.sv
// Bench for adat_rx_tdm_out: random frames against a frame-level reference.
// Expected TDM frames are built as eight {sample, 8'h00} words; a monitor rebuilds frames from bclk rising edges.
// Scenarios: reset, idle, single, back-to-back, overrun, lock loss, mid-frame reset, random soak.
module tb_adat_rx_tdm_out;
    localparam int DIV       = 4;
    localparam int FRAME_CYC = 256 * DIV;

    typedef logic [23:0] chans_t [0:7];

    logic   clk = 1'b0;
    logic   rst_n;
    chans_t ch;
    logic   valid;
    logic   locked;
    logic   bclk, fsync, sdata, busy, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    adat_rx_tdm_out #(.BCLK_DIV(DIV)) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_channels (ch),
        .i_valid    (valid),
        .i_locked   (locked),
        .o_bclk     (bclk),
        .o_fsync    (fsync),
        .o_sdata    (sdata),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- monitor ----------------
    logic         prev_bclk = 1'b0, prev_fsync = 1'b0, prev_busy = 1'b0;
    int           run = 0, phase_bad = 0, park_bad = 0, nbits = 0;
    int           fs_w = 0, bl = 0, bclk_rises = 0;
    logic [255:0] shreg = '0;
    logic [255:0] rx_q [$];
    int           fs_q [$];
    int           fw_q [$];
    int           bl_q [$];

    always @(negedge clk) begin
        // bclk phases while busy must each last DIV/2 cycles
        if (busy) begin
            if (bclk != prev_bclk && run != 0) begin
                if (run != DIV / 2) phase_bad++;
                run = 1;
            end else begin
                run++;
            end
        end else begin
            run = 0;
        end
        if (!busy && (bclk || sdata || fsync)) park_bad++;
        // rebuild frames from data sampled on bclk rising edges
        if (bclk && !prev_bclk) begin
            bclk_rises++;
            if (fsync) nbits = 0;
            shreg = {shreg[254:0], sdata};
            nbits++;
            if (nbits == 256) begin
                rx_q.push_back(shreg);
                nbits = 0;
            end
        end
        if (fsync && !prev_fsync) fs_q.push_back(cyc);
        if (fsync) fs_w++;
        if (!fsync && prev_fsync) begin
            fw_q.push_back(fs_w);
            fs_w = 0;
        end
        if (busy) bl++;
        if (!busy && prev_busy) begin
            bl_q.push_back(bl);
            bl = 0;
        end
        prev_bclk  = bclk;
        prev_fsync = fsync;
        prev_busy  = busy;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] frame_of(input chans_t c);
        logic [255:0] f;
        f = '0;
        for (int s = 0; s < 8; s++) f[255-32*s -: 32] = {c[s], 8'h00};
        return f;
    endfunction

    function automatic int q_at(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic rand_chans(output chans_t c);
        for (int i = 0; i < 8; i++) c[i] = 24'($urandom);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input chans_t c, output int vc);
        @(negedge clk);
        ch    = c;
        valid = 1'b1;
        vc    = cyc;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int want, input int budget);
        int t;
        t = 0;
        while (rx_q.size() < want && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(tag, rx_q.size(), want);
    endtask

    task automatic check_frame(input string tag, input int idx, input chans_t c);
        logic [255:0] got, exp;
        got = (idx < rx_q.size()) ? rx_q[idx] : '0;
        exp = frame_of(c);
        for (int s = 0; s < 8; s++)
            check($sformatf("%s_slot%0d", tag, s), 64'(got[255-32*s -: 32]), 64'(exp[255-32*s -: 32]));
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        chans_t a, b, c;
        int     vc, vb, base, nfs, nfw, nbl, bad, r0, b2b;

        // Reset with random inputs
        rst_n  = 1'b0;
        valid  = 1'b0;
        locked = 1'b0;
        rand_chans(ch);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rand_chans(ch);
            valid  = 1'($urandom);
            locked = 1'($urandom);
            #1;
            if ({bclk, fsync, sdata, busy, overrun} != 5'd0) bad++;
        end
        check("rst_out_cycles", bad, 0);
        check("rst_out_final", {bclk, fsync, sdata, busy, overrun}, 0);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
        r0 = bclk_rises;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            rand_chans(ch);
            locked = 1'($urandom);
        end
        check("idle_bclk_rises", bclk_rises - r0, 0);
        check("idle_busy", busy, 0);

        // Single frame with fixed data
        locked = 1'b1;
        tick(5);
        a[0] = 24'h123456; a[1] = 24'h789ABC; a[2] = 24'hDEF012; a[3] = 24'h345678;
        a[4] = 24'h9ABCDE; a[5] = 24'hF01234; a[6] = 24'h567890; a[7] = 24'hABCDEF;
        base = rx_q.size(); nfs = fs_q.size(); nfw = fw_q.size(); nbl = bl_q.size();
        send(a, vc);
        wait_rx("single_rx", base + 1, 3000);
        tick(20);
        check("single_fsync_lat", q_at(fs_q, nfs) - vc, 2);
        check("single_fsync_width", q_at(fw_q, nfw), DIV);
        check_frame("single", base, a);
        check("single_busy_len", q_at(bl_q, nbl), FRAME_CYC);
        check("single_overrun", overrun, 0);

        // Back-to-back frames
        rand_chans(a);
        rand_chans(b);
        base = rx_q.size(); nfs = fs_q.size(); nbl = bl_q.size();
        send(a, vc);
        tick(498);
        send(b, vb);
        wait_rx("b2b_rx", base + 2, 4000);
        tick(20);
        check("b2b_fsync_gap", q_at(fs_q, nfs + 1) - q_at(fs_q, nfs), FRAME_CYC);
        check("b2b_busy_len", q_at(bl_q, nbl), 2 * FRAME_CYC);
        check_frame("b2b_f1", base, a);
        check_frame("b2b_f2", base + 1, b);
        check("b2b_overrun", overrun, 0);

        // Overrun: second write overwritten by the third
        rand_chans(a);
        rand_chans(b);
        rand_chans(c);
        base = rx_q.size();
        send(a, vc);
        tick(298);
        send(b, vb);
        tick(298);
        send(c, vb);
        tick(5);
        check("ovr_set", overrun, 1);
        wait_rx("ovr_rx", base + 2, 4000);
        check_frame("ovr_f1", base, a);
        check_frame("ovr_f2", base + 1, c);
        tick(1100);
        check("ovr_frame_count", rx_q.size(), base + 2);
        locked = 1'b0;
        tick(5);
        check("ovr_sticky_unlocked", overrun, 1);
        locked = 1'b1;
        tick(3);
        check("ovr_clear_on_relock", overrun, 0);

        // Lock loss: valid while unlocked is ignored
        locked = 1'b0;
        tick(3);
        rand_chans(a);
        base = rx_q.size();
        send(a, vc);
        tick(1500);
        check("unlocked_no_frame", rx_q.size(), base);
        check("unlocked_busy", busy, 0);
        locked = 1'b1;
        tick(3);

        // Lock drop mid-frame with a frame pending
        rand_chans(a);
        rand_chans(b);
        base = rx_q.size(); nbl = bl_q.size();
        send(a, vc);
        tick(98);
        send(b, vb);
        tick(298);
        locked = 1'b0;
        wait_rx("lockdrop_rx", base + 1, 2000);
        tick(1500);
        check("lockdrop_count", rx_q.size(), base + 1);
        check_frame("lockdrop", base, a);
        check("lockdrop_busy_len", q_at(bl_q, nbl), FRAME_CYC);
        check("lockdrop_idle", busy, 0);
        locked = 1'b1;
        tick(3);

        // Reset pulse mid-frame
        rand_chans(a);
        rand_chans(b);
        base = rx_q.size();
        send(a, vc);
        tick(300);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {bclk, fsync, sdata, busy, overrun}, 0);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check("midrst_abandoned", rx_q.size(), base);
        nfs = fs_q.size();
        send(b, vb);
        wait_rx("midrst_rx", base + 1, 3000);
        tick(20);
        check_frame("midrst", base, b);
        check("midrst_fsync_lat", q_at(fs_q, nfs) - vb, 2);
        check("midrst_overrun", overrun, 0);

        // Random soak: single or back-to-back frames at random offsets
        for (int it = 0; it < 6; it++) begin
            rand_chans(a);
            rand_chans(b);
            b2b  = int'($urandom_range(0, 1));
            base = rx_q.size(); nfs = fs_q.size();
            send(a, vc);
            if (b2b != 0) begin
                tick(int'($urandom_range(5, 1000)));
                send(b, vb);
            end
            wait_rx($sformatf("soak%0d_rx", it), base + 1 + b2b, 4000);
            tick(20);
            check_frame($sformatf("soak%0d_f1", it), base, a);
            if (b2b != 0) begin
                check_frame($sformatf("soak%0d_f2", it), base + 1, b);
                check($sformatf("soak%0d_gap", it), q_at(fs_q, nfs + 1) - q_at(fs_q, nfs), FRAME_CYC);
            end
            check($sformatf("soak%0d_overrun", it), overrun, 0);
            tick(int'($urandom_range(1, 50)));
        end

        check("bclk_phase_errors", phase_bad, 0);
        check("idle_park_errors", park_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
